// File: rtl/panel_ctrl_pkg.sv
// Shared types and constants for the front-panel controller.
package panel_ctrl_pkg;

  localparam int unsigned INIT_W = 3;
  localparam int unsigned WAT_W  = 6;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned PM_CNT = 6;
  localparam int unsigned PW_DEF = 3;
  localparam int unsigned PW_MAX = 5;

  typedef enum logic [2:0] {
    PS_OFF,
    PS_SETUP,
    PS_START,
    PS_RUN,
    PS_PAUSE,
    PS_FIN
  } panel_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAT_W-1:0] wat;
  } panel_cfg_t;

  // Program index to run_mode stage mask; never yields an empty mask.
  function automatic logic [INIT_W-1:0] mode_init(input logic [IDX_W-1:0] idx);
    logic [INIT_W-1:0] m;
    case (idx)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b001;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b110;
      3'd5:    m = 3'b100;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx >= IDX_W'(PM_CNT - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  function automatic logic [WAT_W-1:0] next_wat(input logic [WAT_W-1:0] wat);
    return (wat >= WAT_W'(PW_MAX)) ? WAT_W'(1) : wat + WAT_W'(1);
  endfunction

endpackage

// File: rtl/panel_ctrl_down_timer.sv
// Loadable down counter with a zero flag; clear has priority over load.
module panel_ctrl_down_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel controller: button pulses to run_mode init/u_wat/pau/clr plus finish beeper.
module panel_ctrl
  import panel_ctrl_pkg::*;
#(
  parameter int unsigned BEEP_CMAX = 150_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_pwr,
  input  logic              btn_start,
  input  logic              btn_mode,
  input  logic              btn_wat,
  input  logic              done,
  output logic [INIT_W-1:0] init,
  output logic [WAT_W-1:0]  u_wat,
  output logic              pau,
  output logic              clr,
  output logic              pwr_on,
  output logic              running,
  output logic              beep
);

  localparam int unsigned CNT_W = (BEEP_CMAX > 1) ? $clog2(BEEP_CMAX) : 1;

  panel_state_e state_q, state_d;
  panel_cfg_t   cfg_q, cfg_d;
  logic         tmr_clr, tmr_load, tmr_dec, tmr_zero_c;
  logic         pau_d, clr_d, running_d, pwr_on_d, beep_d;

  panel_ctrl_down_timer #(
    .W (CNT_W)
  ) u_down_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (CNT_W'(BEEP_CMAX - 1)),
    .dec      (tmr_dec),
    .zero_c   (tmr_zero_c)
  );

  // Next state, settings and timer control; buttons resolved in priority order.
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    if (state_q != PS_OFF && btn_pwr) begin
      state_d = PS_OFF;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        PS_OFF: begin
          if (btn_pwr) begin
            state_d   = PS_SETUP;
            cfg_d.idx = '0;
            cfg_d.wat = WAT_W'(PW_DEF);
          end
        end
        PS_SETUP: begin
          if (btn_start)     state_d   = PS_START;
          else if (btn_mode) cfg_d.idx = next_idx(cfg_q.idx);
          else if (btn_wat)  cfg_d.wat = next_wat(cfg_q.wat);
        end
        PS_START: state_d = PS_RUN;
        PS_RUN: begin
          if (done) begin
            state_d  = PS_FIN;
            tmr_load = 1'b1;
          end else if (btn_start) begin
            state_d = PS_PAUSE;
          end
        end
        PS_PAUSE: begin
          if (btn_start) state_d = PS_RUN;
        end
        PS_FIN: begin
          if (btn_start) begin
            state_d = PS_SETUP;
            tmr_clr = 1'b1;
          end else if (tmr_zero_c) begin
            state_d = PS_SETUP;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: state_d = PS_OFF;
      endcase
    end

    pau_d     = !(state_d == PS_START || state_d == PS_RUN);
    clr_d     = (state_d == PS_START);
    running_d = (state_d == PS_RUN || state_d == PS_PAUSE);
    pwr_on_d  = (state_d != PS_OFF);
    beep_d    = (state_d == PS_FIN);
  end

  // State, settings and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PS_OFF;
      cfg_q   <= '{idx: '0, wat: WAT_W'(PW_DEF)};
      init    <= mode_init('0);
      u_wat   <= WAT_W'(PW_DEF);
      pau     <= 1'b1;
      clr     <= 1'b0;
      running <= 1'b0;
      pwr_on  <= 1'b0;
      beep    <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      init    <= mode_init(cfg_d.idx);
      u_wat   <= cfg_d.wat;
      pau     <= pau_d;
      clr     <= clr_d;
      running <= running_d;
      pwr_on  <= pwr_on_d;
      beep    <= beep_d;
    end
  end

endmodule

// File: tb/tb_panel_ctrl.sv
// Self-checking bench for panel_ctrl: directed scenarios plus random button traffic vs a reference model.
module tb_panel_ctrl;

  localparam int unsigned BEEP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_pwr = 1'b0, btn_start = 1'b0, btn_mode = 1'b0, btn_wat = 1'b0, done = 1'b0;
  logic [2:0] init;
  logic [5:0] u_wat;
  logic       pau, clr, pwr_on, running, beep;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [2:0] tbl [6] = '{3'b111, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

  // Reference model: power flag, one-cycle load flag, run/pause flags, beep cycles remaining.
  bit m_on, m_load, m_run, m_paused;
  int m_beep, m_idx, m_wat;

  panel_ctrl #(.BEEP_CMAX(BEEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_pwr   (btn_pwr),
    .btn_start (btn_start),
    .btn_mode  (btn_mode),
    .btn_wat   (btn_wat),
    .done      (done),
    .init      (init),
    .u_wat     (u_wat),
    .pau       (pau),
    .clr       (clr),
    .pwr_on    (pwr_on),
    .running   (running),
    .beep      (beep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on = 0; m_load = 0; m_run = 0; m_paused = 0;
      m_beep = 0; m_idx = 0; m_wat = 3;
    end else if (!m_on) begin
      if (btn_pwr) begin
        m_on = 1; m_idx = 0; m_wat = 3;
      end
    end else if (btn_pwr) begin
      m_on = 0; m_load = 0; m_run = 0; m_paused = 0; m_beep = 0;
    end else if (m_load) begin
      m_load = 0; m_run = 1; m_paused = 0;
    end else if (m_beep > 0) begin
      m_beep = btn_start ? 0 : m_beep - 1;
    end else if (m_run) begin
      if (!m_paused) begin
        if (done) begin
          m_run = 0; m_beep = BEEP;
        end else if (btn_start) begin
          m_paused = 1;
        end
      end else if (btn_start) begin
        m_paused = 0;
      end
    end else begin
      if (btn_start)     m_load = 1;
      else if (btn_mode) m_idx = (m_idx + 1) % 6;
      else if (btn_wat)  m_wat = (m_wat % 5) + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("init",    int'(init),    int'(tbl[m_idx]));
      chk("u_wat",   int'(u_wat),   m_wat);
      chk("pau",     int'(pau),     int'(!(m_load || (m_run && !m_paused))));
      chk("clr",     int'(clr),     int'(m_load));
      chk("running", int'(running), int'(m_run));
      chk("pwr_on",  int'(pwr_on),  int'(m_on));
      chk("beep",    int'(beep),    int'(m_beep > 0));
    end
  end

  task automatic step(input bit p, input bit s, input bit m, input bit w, input bit d);
    @(negedge clk);
    btn_pwr = p; btn_start = s; btn_mode = m; btn_wat = w; done = d;
    @(posedge clk);
    #1;
    btn_pwr = 0; btn_start = 0; btn_mode = 0; btn_wat = 0; done = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pau"},     int'(pau),     1);
    chk({tag, "_pwr_on"},  int'(pwr_on),  0);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_beep"},    int'(beep),    0);
    chk({tag, "_clr"},     int'(clr),     0);
    chk({tag, "_init"},    int'(init),    7);
    chk({tag, "_u_wat"},   int'(u_wat),   3);
  endtask

  initial begin
    int nb;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst");
    cmp_en = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;

    step(1, 0, 0, 0, 0);
    chk("pwr_on_after_pwr", int'(pwr_on), 1);

    repeat (3) step(0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 1, 0);
    chk("init_mode3", int'(init), 2);
    chk("u_wat_2", int'(u_wat), 2);
    repeat (6) step(0, 0, 1, 0, 0);
    chk("init_wrap", int'(init), 2);

    step(0, 1, 0, 0, 0);
    chk("start_clr", int'(clr), 1);
    chk("start_pau", int'(pau), 0);
    chk("start_running", int'(running), 0);
    step(0, 0, 1, 0, 0);
    chk("run_clr", int'(clr), 0);
    chk("run_running", int'(running), 1);
    chk("run_mode_ignored", int'(init), 2);

    step(0, 1, 0, 0, 0);
    chk("pause_pau", int'(pau), 1);
    step(0, 0, 0, 0, 1);
    chk("pause_done_ignored", int'(beep), 0);
    step(0, 1, 0, 0, 0);
    chk("resume_pau", int'(pau), 0);
    step(0, 0, 0, 0, 1);
    nb = beep ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (beep) nb++;
    end
    chk("beep_len", nb, 8);
    chk("fin_setup_running", int'(running), 0);
    chk("fin_setup_pwr_on", int'(pwr_on), 1);
    chk("fin_setup_init", int'(init), 2);

    step(0, 1, 0, 0, 0);
    idle();
    step(0, 1, 0, 0, 1);
    chk("done_wins_beep", int'(beep), 1);
    chk("done_wins_running", int'(running), 0);
    step(1, 0, 1, 0, 0);
    chk("pwr_mode_off", int'(pwr_on), 0);
    chk("pwr_mode_init_kept", int'(init), 2);
    chk("off_beep", int'(beep), 0);
    step(1, 0, 0, 0, 0);
    chk("reload_init", int'(init), 7);
    chk("reload_u_wat", int'(u_wat), 3);

    step(0, 1, 0, 0, 0);
    idle();
    chk("pre_rst_running", int'(running), 1);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 8);
      if ($urandom_range(0, 299) == 0) begin
        #3 rst_n = 1'b0;
        #1 chk("rnd_rst_pwr_on", int'(pwr_on), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end

    idle();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
